// File: rtl/iob_skid_buf_pkg.sv
// Shared definitions for valid/ready pipeline stages.
//   skid_state_t : occupancy state of a two-entry stage
//                  (ST_EMPTY = 0, ST_BUSY = 1, ST_FULL = 2)
//   STATE_W      : width of the encoded state
//   state_level  : maps a state to its occupancy count 0..2
package iob_skid_buf_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    function automatic logic [1:0] state_level(input skid_state_t s);
        case (s)
            ST_BUSY: return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/iob_reg.sv
// Plain enabled register with asynchronous active-high reset.
//   clk_i   in  1       clock
//   arst_i  in  1       asynchronous reset, loads RST_VAL
//   cke_i   in  1       clock enable; 0 holds the stored value
//   data_i  in  DATA_W  next value
//   data_o  out DATA_W  stored value
module iob_reg #(
    parameter int                 DATA_W  = 1,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o <= RST_VAL;
        end else if (cke_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/iob_skid_buf.sv
// Two-entry valid/ready skid buffer with registered outputs in both directions.
// in_ready_o is decoded from the state register only, so there is no
// combinational path from out_ready_i to in_ready_o.
//
// Handshake: a word moves across an interface on a rising clk_i edge where
// cke_i=1 and both valid and ready are 1. A producer holding valid=1 keeps
// its word offered until it is taken; out_data_o is held stable while
// out_valid_o=1 and out_ready_i=0.
//
//   clk_i        in   1       clock
//   arst_i       in   1       asynchronous reset, active-high
//   cke_i        in   1       clock enable; 0 freezes all state
//   flush_i      in   1       synchronous clear (only when cke_i=1)
//   in_valid_i   in   1       upstream data valid
//   in_data_i    in   DATA_W  upstream payload
//   in_ready_o   out  1       buffer can accept (registered)
//   out_valid_o  out  1       out_data_o holds valid data (registered)
//   out_data_o   out  DATA_W  payload at head of buffer (registered)
//   out_ready_i  in   1       downstream accepts
//   level_o      out  2       occupancy 0..2
//   state_o      out  2       current FSM state (debug)
module iob_skid_buf
    import iob_skid_buf_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        level_o,
    output logic [1:0]        state_o
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_bits_d;
    skid_state_t        state;
    skid_state_t        state_d;
    logic [DATA_W-1:0]  main_q;
    logic [DATA_W-1:0]  main_d;
    logic [DATA_W-1:0]  skid_q;
    logic [DATA_W-1:0]  skid_d;
    logic               in_acc;
    logic               out_acc;

    assign state        = skid_state_t'(state_q);
    assign state_bits_d = state_d;

    assign out_valid_o = (state != ST_EMPTY);
    assign in_ready_o  = (state != ST_FULL);
    assign level_o     = state_level(state);
    assign state_o     = state_q;
    assign out_data_o  = main_q;

    assign in_acc  = cke_i & in_valid_i & in_ready_o;
    assign out_acc = cke_i & out_valid_o & out_ready_i;

    always_comb begin
        state_d = state;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state)
            ST_EMPTY: begin
                if (in_acc) begin
                    main_d  = in_data_i;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_acc && out_acc) begin
                    main_d = in_data_i;
                end else if (in_acc) begin
                    // Downstream stalled: park the new word behind the head.
                    skid_d  = in_data_i;
                    state_d = ST_FULL;
                end else if (out_acc) begin
                    // main keeps its stale value; out_valid_o masks it.
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_acc) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Flush wins over any same-cycle transfer; the registers only load
        // it when cke_i=1, which gives the "only with clock enable" rule.
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end
    end

    iob_reg #(.DATA_W(STATE_W), .RST_VAL(ST_EMPTY)) u_state_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_i (state_bits_d),
        .data_o (state_q)
    );

    iob_reg #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_main_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_i (main_d),
        .data_o (main_q)
    );

    iob_reg #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_skid_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_i (skid_d),
        .data_o (skid_q)
    );

endmodule

// File: tb/tb_iob_skid_buf.sv
// Self-checking bench for iob_skid_buf with DATA_W=16, RST_VAL=0.
module tb_iob_skid_buf;

    localparam int W = 16;

    logic         clk;
    logic         arst;
    logic         cke;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   level;
    logic [1:0]   state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         c;
        logic         f;
        logic         e_valid;
        logic [W-1:0] e_data;
        logic         e_ready;
        logic [1:0]   e_level;
    } vec_t;

    vec_t tbl[18];

    iob_skid_buf #(.DATA_W(W), .RST_VAL(16'h0000)) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .cke_i       (cke),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .level_o     (level),
        .state_o     (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic r,
                                input logic c, input logic f, input logic ev,
                                input logic [W-1:0] ed, input logic er, input logic [1:0] el);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.c = c; t.f = f;
        t.e_valid = ev; t.e_data = ed; t.e_ready = er; t.e_level = el;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r,
                         input logic c, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        cke       = c;
        flush     = f;
    endtask

    // advance one edge and land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [W-1:0] ed,
                              input logic er, input logic [1:0] el);
        check({tag, ".valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".data"},  32'(out_data),  32'(ed));
        check({tag, ".ready"}, 32'(in_ready),  32'(er));
        check({tag, ".level"}, 32'(level),     32'(el));
    endtask

    // ---------------- test ----------------
    initial begin
        // stall / clock-enable / flush sequence, starting from EMPTY
        tbl[0]  = mk(1, 16'h000A, 0, 1, 0,  1, 16'h000A, 1, 2'd1);
        tbl[1]  = mk(1, 16'h000B, 0, 1, 0,  1, 16'h000A, 0, 2'd2);
        tbl[2]  = mk(1, 16'h000C, 0, 1, 0,  1, 16'h000A, 0, 2'd2);
        tbl[3]  = mk(0, 16'h0000, 1, 1, 0,  1, 16'h000B, 1, 2'd1);
        tbl[4]  = mk(0, 16'h0000, 1, 1, 0,  0, 16'h000B, 1, 2'd0);
        tbl[5]  = mk(1, 16'h00C1, 0, 1, 0,  1, 16'h00C1, 1, 2'd1);
        tbl[6]  = mk(1, 16'h00C2, 0, 1, 0,  1, 16'h00C1, 0, 2'd2);
        tbl[7]  = mk(0, 16'h0000, 1, 0, 0,  1, 16'h00C1, 0, 2'd2);
        tbl[8]  = mk(0, 16'h0000, 1, 0, 0,  1, 16'h00C1, 0, 2'd2);
        tbl[9]  = mk(0, 16'h0000, 1, 0, 0,  1, 16'h00C1, 0, 2'd2);
        tbl[10] = mk(0, 16'h0000, 1, 1, 0,  1, 16'h00C2, 1, 2'd1);
        tbl[11] = mk(1, 16'h00D1, 1, 1, 0,  1, 16'h00D1, 1, 2'd1);
        tbl[12] = mk(1, 16'h00D2, 0, 1, 0,  1, 16'h00D1, 0, 2'd2);
        tbl[13] = mk(1, 16'h00D3, 1, 1, 1,  0, 16'h0000, 1, 2'd0);
        tbl[14] = mk(0, 16'h0000, 1, 1, 0,  0, 16'h0000, 1, 2'd0);
        tbl[15] = mk(1, 16'h00E1, 0, 1, 0,  1, 16'h00E1, 1, 2'd1);
        tbl[16] = mk(0, 16'h0000, 1, 0, 1,  1, 16'h00E1, 1, 2'd1);
        tbl[17] = mk(0, 16'h0000, 1, 1, 0,  0, 16'h00E1, 1, 2'd0);

        // ---- 1: reset ----
        arst = 1'b1;
        drive(0, '0, 0, 1, 0);
        #12;
        check_outs("reset", 1'b0, 16'h0000, 1'b1, 2'd0);
        check("reset.state", 32'(state), 32'd0);
        #10;
        arst = 1'b0;
        step();

        // ---- 2: stream 1..8, one per cycle, 1-cycle latency ----
        for (int k = 1; k <= 8; k++) begin
            drive(1, W'(k), 1, 1, 0);
            step();
            check_outs($sformatf("stream%0d", k), 1'b1, W'(k), 1'b1, 2'd1);
        end
        drive(0, '0, 1, 1, 0);
        step();
        check_outs("stream_end", 1'b0, 16'h0008, 1'b1, 2'd0);

        // ---- 3/5/6: table of stall, clock-enable and flush cycles ----
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c, tbl[i].f);
            step();
            check_outs($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_data,
                       tbl[i].e_ready, tbl[i].e_level);
        end

        // ---- asynchronous reset while FULL, then first accept after release ----
        drive(1, 16'h0031, 0, 1, 0);
        step();
        drive(1, 16'h0032, 0, 1, 0);
        step();
        check("prereset.level", 32'(level), 32'd2);
        #2;
        arst = 1'b1;
        #1;
        check_outs("midreset", 1'b0, 16'h0000, 1'b1, 2'd0);
        drive(1, 16'h0055, 0, 1, 0);
        @(negedge clk);
        arst = 1'b0;
        step();
        check_outs("post_reset_accept", 1'b1, 16'h0055, 1'b1, 2'd1);

        // ---- 4: random valid/ready with clock-enable gaps, scoreboard ----
        exp_q.push_back(16'h0055);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic rdy_before;
            drive(($urandom_range(0, 99) < 60), W'($urandom_range(0, 65535)),
                  ($urandom_range(0, 99) < 55), ($urandom_range(0, 9) != 0), 1'b0);
            @(negedge clk);
            check("rnd.level", 32'(level), 32'(exp_q.size()));
            check("rnd.valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (cke && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd.unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("rnd.data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            if (cke && in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
            // in_ready must not follow a same-cycle change of out_ready
            if (cyc % 16 == 0) begin
                rdy_before = in_ready;
                out_ready  = ~out_ready;
                #1;
                check("rnd.ready_indep", 32'(in_ready), 32'(rdy_before));
                out_ready  = ~out_ready;
            end
            step();
        end

        // drain what is left, bounded
        drive(0, '0, 1, 1, 0);
        for (int i = 0; i < 6 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check("drain.data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            step();
        end
        check("drain.left", 32'(exp_q.size()), 32'd0);
        #1;
        check("drain.level", 32'(level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
